// File: rtl/counter_stream_if.sv
// counter_stream_if: command and output-stream signals of counter_stream.
// The master modport is the counter_stream side, the slave modport is the user side.
interface counter_stream_if #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [WIDTH-1:0]     cmd_start;
    logic [WIDTH-1:0]     cmd_step;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 valid;
    logic                 ready;
    logic [WIDTH-1:0]     data;
    logic                 last;

    modport master (
        input  cmd_valid, cmd_start, cmd_step, cmd_len, ready,
        output cmd_ready, valid, data, last
    );

    modport slave (
        output cmd_valid, cmd_start, cmd_step, cmd_len, ready,
        input  cmd_ready, valid, data, last
    );
endinterface

// File: rtl/counter_stream.sv
// counter_stream: command-driven arithmetic-sequence burst source with a
// valid/ready output. Each accepted command (start, step, len) produces
// len+1 beats start, start+step, ... with last on the final beat.
// Optional feature macro: COUNTER_STREAM_BEAT_COUNT_EN adds a 32-bit
// beat_count port counting every output handshake.
module counter_stream #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    counter_stream_if.master bus
`ifdef COUNTER_STREAM_BEAT_COUNT_EN
    ,
    output logic [31:0]      beat_count
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_cmd_ready;
    logic                 r_valid;
    logic                 r_last;
    logic [WIDTH-1:0]     r_data;
    logic [WIDTH-1:0]     r_step;
    logic [LEN_WIDTH-1:0] r_rem;

    logic                 w_cmd_ready_nxt;
    logic                 w_valid_nxt;
    logic                 w_last_nxt;
    logic [WIDTH-1:0]     w_data_nxt;
    logic [WIDTH-1:0]     w_step_nxt;
    logic [LEN_WIDTH-1:0] w_rem_nxt;

    logic                 w_cmd_fire;
    logic                 w_beat_fire;

    // cmd_ready is only ever high in IDLE, so a command fire implies IDLE
    assign w_cmd_fire  = bus.cmd_valid && r_cmd_ready;
    assign w_beat_fire = r_valid && bus.ready;

    // Next-state and next-register values; every output is registered
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_valid_nxt     = r_valid;
        w_last_nxt      = r_last;
        w_data_nxt      = r_data;
        w_step_nxt      = r_step;
        w_rem_nxt       = r_rem;

        case (r_state)
            S_IDLE: begin
                // cmd_ready comes up one edge after reset release and stays up
                w_cmd_ready_nxt = 1'b1;
                w_valid_nxt     = 1'b0;
                w_last_nxt      = 1'b0;
                if (w_cmd_fire) begin
                    w_data_nxt      = bus.cmd_start;
                    w_step_nxt      = bus.cmd_step;
                    w_rem_nxt       = bus.cmd_len;
                    w_last_nxt      = (bus.cmd_len == '0);
                    w_valid_nxt     = 1'b1;
                    w_cmd_ready_nxt = 1'b0;
                    w_state_nxt     = S_RUN;
                end
            end

            S_RUN: begin
                w_cmd_ready_nxt = 1'b0;
                if (w_beat_fire) begin
                    if (r_last) begin
                        w_valid_nxt     = 1'b0;
                        w_last_nxt      = 1'b0;
                        w_cmd_ready_nxt = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        // modulo-2^WIDTH add; a step of all-ones counts down
                        w_data_nxt = r_data + r_step;
                        // never reached with r_rem==0 because last is set at 1
                        w_rem_nxt  = r_rem - LEN_WIDTH'(1);
                        w_last_nxt = (r_rem == LEN_WIDTH'(1));
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and burst registers; reset clears everything so a burst
    // interrupted by reset leaves nothing behind
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmd_ready <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_step      <= '0;
            r_rem       <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
            r_data      <= w_data_nxt;
            r_step      <= w_step_nxt;
            r_rem       <= w_rem_nxt;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.valid     = r_valid;
    assign bus.data      = r_data;
    assign bus.last      = r_last;

`ifdef COUNTER_STREAM_BEAT_COUNT_EN
    logic [31:0] r_beat_count;

    // Running total of output handshakes, wraps at 2^32, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_beat_count <= '0;
        end else if (w_beat_fire) begin
            r_beat_count <= r_beat_count + 32'd1;
        end
    end

    assign beat_count = r_beat_count;
`endif

endmodule
